// File: rtl/p405s_dtlb_pkg.sv
// Shared constants, FSM encodings and the size-mask bit mapping for the data shadow TLB.
package p405s_dtlb_pkg;

    localparam int DEF_ENTRIES = 4;
    localparam int DEF_EPN_W   = 22;
    localparam int DEF_SIZE_W  = 7;
    localparam int DEF_ATTR_W  = 8;

    typedef logic [1:0] dsa_state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    localparam int ATTR_BIT_I    = 0;
    localparam int ATTR_BIT_E    = 1;
    localparam int ATTR_BIT_U0   = 2;
    localparam int ATTR_BIT_W    = 3;
    localparam int ATTR_BIT_G    = 4;
    localparam int ATTR_BIT_WR   = 5;
    localparam int ATTR_BIT_ZPR0 = 6;
    localparam int ATTR_BIT_ZPR1 = 7;

    // Size-mask bit that covers page bit j, or -1 when that bit is never maskable.
    function automatic int mask_index(input int j, input int epn_w, input int size_w);
        int k;
        if (j < epn_w - 14) return -1;
        k = (j - (epn_w - 14)) / 2;
        if (k >= size_w) return -1;
        return k;
    endfunction

endpackage

// File: rtl/p405s_dtlb_dsarray_if.sv
// Lookup and refill bus between the EXE pipeline / unified TLB and the shadow TLB.
interface p405s_dtlb_dsarray_if
    import p405s_dtlb_pkg::*;
#(
    parameter int EPN_W  = DEF_EPN_W,
    parameter int SIZE_W = DEF_SIZE_W,
    parameter int ATTR_W = DEF_ATTR_W
);
    logic [0:EPN_W-1]  EXE_eaARegBuf;
    logic [0:EPN_W-1]  EXE_eaBRegBuf;
    logic              lookupVal;
    logic              msrDR;
    logic              invalidate;
    logic              Hit;
    logic              Miss;
    logic [0:EPN_W-1]  RA;
    logic [0:ATTR_W-1] attr_out;
    logic              busy;
    logic              missReq;
    logic [0:EPN_W-1]  missEPN;
    logic              missAck;
    logic [0:EPN_W-1]  fillRPN;
    logic [0:EPN_W-1]  fillEPN;
    logic [0:SIZE_W-1] fillDSize;
    logic [0:ATTR_W-1] fillAttr;

    modport master (
        output EXE_eaARegBuf, EXE_eaBRegBuf, lookupVal, msrDR, invalidate,
        output missAck, fillRPN, fillEPN, fillDSize, fillAttr,
        input  Hit, Miss, RA, attr_out, busy, missReq, missEPN
    );

    modport slave (
        input  EXE_eaARegBuf, EXE_eaBRegBuf, lookupVal, msrDR, invalidate,
        input  missAck, fillRPN, fillEPN, fillDSize, fillAttr,
        output Hit, Miss, RA, attr_out, busy, missReq, missEPN
    );
endinterface

// File: rtl/p405s_dtlb_dsEntry.sv
// One shadow TLB entry: payload storage, valid bit, masked page compare and RA munge.
module p405s_dtlb_dsEntry
    import p405s_dtlb_pkg::*;
#(
    parameter int EPN_W  = DEF_EPN_W,
    parameter int SIZE_W = DEF_SIZE_W,
    parameter int ATTR_W = DEF_ATTR_W
) (
    input  logic              CB,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [0:EPN_W-1]  ea,
    input  logic [0:EPN_W-1]  wr_epn,
    input  logic [0:EPN_W-1]  wr_rpn,
    input  logic [0:SIZE_W-1] wr_size,
    input  logic [0:ATTR_W-1] wr_attr,
    output logic              valid,
    output logic              match,
    output logic [0:EPN_W-1]  ra,
    output logic [0:ATTR_W-1] attr
);
    logic [0:EPN_W-1]  epn_q;
    logic [0:EPN_W-1]  rpn_q;
    logic [0:SIZE_W-1] size_q;
    logic [0:ATTR_W-1] attr_q;
    logic [0:EPN_W-1]  mask;

    always_ff @(posedge CB) begin
        if (reset || clear) valid <= 1'b0;
        else if (wr_en)     valid <= 1'b1;
    end

    // Payload is deliberately left unreset; the valid bit guards it.
    always_ff @(posedge CB) begin
        if (wr_en) begin
            epn_q  <= wr_epn;
            rpn_q  <= wr_rpn;
            size_q <= wr_size;
            attr_q <= wr_attr;
        end
    end

    for (genvar j = 0; j < EPN_W; j++) begin : g_mask
        localparam int K = mask_index(j, EPN_W, SIZE_W);
        if (K < 0) begin : g_fixed
            assign mask[j] = 1'b0;
        end else begin : g_sized
            assign mask[j] = size_q[K];
        end
    end

    assign match = valid && (((ea ^ epn_q) & ~mask) == '0);
    assign ra    = rpn_q | (ea & mask);
    assign attr  = attr_q;

endmodule

// File: rtl/p405s_dtlb_dsarray.sv
// Data shadow TLB: EA adder, fully associative lookup, registered results and miss refill FSM.
module p405s_dtlb_dsarray
    import p405s_dtlb_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int EPN_W   = DEF_EPN_W,
    parameter int SIZE_W  = DEF_SIZE_W,
    parameter int ATTR_W  = DEF_ATTR_W
) (
    input  logic                CB,
    input  logic                reset,
    p405s_dtlb_dsarray_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    dsa_state_t        state;
    logic [0:EPN_W-1]  ea;
    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] match;
    logic [0:EPN_W-1]  ent_ra   [ENTRIES];
    logic [0:ATTR_W-1] ent_attr [ENTRIES];
    logic              any_match;
    logic [0:EPN_W-1]  win_ra;
    logic [0:ATTR_W-1] win_attr;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  victim;
    logic              victim_is_rr;
    logic              accept;
    logic              do_fill;
    logic [0:EPN_W-1]  fill_epn_q;
    logic [0:EPN_W-1]  fill_rpn_q;
    logic [0:SIZE_W-1] fill_size_q;
    logic [0:ATTR_W-1] fill_attr_q;

    assign ea          = bus.EXE_eaARegBuf + bus.EXE_eaBRegBuf;
    assign accept      = bus.lookupVal && (state == ST_IDLE) && !bus.invalidate;
    assign do_fill     = (state == ST_FILL) && !bus.invalidate && !reset;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.missReq = (state == ST_REQ);

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        p405s_dtlb_dsEntry #(
            .EPN_W  (EPN_W),
            .SIZE_W (SIZE_W),
            .ATTR_W (ATTR_W)
        ) u_entry (
            .CB      (CB),
            .reset   (reset),
            .clear   (bus.invalidate),
            .wr_en   (do_fill && (victim == IDX_W'(i))),
            .ea      (ea),
            .wr_epn  (fill_epn_q),
            .wr_rpn  (fill_rpn_q),
            .wr_size (fill_size_q),
            .wr_attr (fill_attr_q),
            .valid   (valid[i]),
            .match   (match[i]),
            .ra      (ent_ra[i]),
            .attr    (ent_attr[i])
        );
    end

    // Walking down from the top leaves the lowest matching index as the winner.
    always_comb begin
        any_match = 1'b0;
        win_ra    = '0;
        win_attr  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                any_match = 1'b1;
                win_ra    = ent_ra[i];
                win_attr  = ent_attr[i];
            end
        end
    end

    always_comb begin
        victim       = rr_ptr;
        victim_is_rr = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                victim       = IDX_W'(i);
                victim_is_rr = 1'b0;
            end
        end
    end

    always_ff @(posedge CB) begin
        if (state == ST_REQ && bus.missAck && !bus.invalidate) begin
            fill_epn_q  <= bus.fillEPN;
            fill_rpn_q  <= bus.fillRPN;
            fill_size_q <= bus.fillDSize;
            fill_attr_q <= bus.fillAttr;
        end
    end

    // Hit/Miss are one-cycle pulses; RA/attr_out hold their last translation.
    always_ff @(posedge CB) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            bus.Hit      <= 1'b0;
            bus.Miss     <= 1'b0;
            bus.RA       <= '0;
            bus.attr_out <= '0;
            bus.missEPN  <= '0;
        end else begin
            bus.Hit  <= 1'b0;
            bus.Miss <= 1'b0;
            if (accept) begin
                if (!bus.msrDR) begin
                    bus.Hit      <= 1'b1;
                    bus.RA       <= ea;
                    bus.attr_out <= '0;
                end else if (any_match) begin
                    bus.Hit      <= 1'b1;
                    bus.RA       <= win_ra;
                    bus.attr_out <= win_attr;
                end else begin
                    bus.Miss    <= 1'b1;
                    bus.missEPN <= ea;
                end
            end
            case (state)
                ST_IDLE: if (accept && bus.msrDR && !any_match) state <= ST_REQ;
                ST_REQ: begin
                    if (bus.invalidate)   state <= ST_IDLE;
                    else if (bus.missAck) state <= ST_FILL;
                end
                ST_FILL: begin
                    state <= ST_IDLE;
                    if (do_fill && victim_is_rr)
                        rr_ptr <= (rr_ptr == IDX_W'(ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/p405s_dtlb_dsarray.md
# p405s_dtlb_dsArray

Parametrised data shadow TLB: `ENTRIES` fully associative page entries, each holding EPN, size mask, RPN and storage attributes. It sits between the EXE-stage address operands and the unified TLB. Each cycle it forms the effective page from `EXE_eaARegBuf` + `EXE_eaBRegBuf`, compares it against all valid entries, and returns a registered hit/miss, the munged real address and the attributes. On a miss it runs a request/acknowledge refill from the unified TLB into a victim entry.

## Interface
- `ENTRIES`, 4: number of shadow entries; 2..16.
- `EPN_W`, 22: page-number width, bits [0:EPN_W-1].
- `SIZE_W`, 7: size-mask width; mask bit k covers EPN bits EPN_W-14+2k and EPN_W-13+2k.
- `ATTR_W`, 8: attribute width, ordered {I,E,U0,W,G,WR,zonePR[0:1]}.

Ports:
- `CB` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `EXE_eaARegBuf` in EPN_W: EA operand A.
- `EXE_eaBRegBuf` in EPN_W: EA operand B.
- `lookupVal` in 1: lookup request this cycle.
- `msrDR` in 1: data relocation enable.
- `invalidate` in 1: invalidate all entries.
- `Hit` out 1: registered; translation valid.
- `Miss` out 1: registered; lookup missed, refill started.
- `RA` out EPN_W: registered real page number.
- `attr_out` out ATTR_W: registered attributes.
- `busy` out 1: refill FSM not IDLE.
- `missReq` out 1: refill request to the unified TLB.
- `missEPN` out EPN_W: page being refilled; stable while `missReq` is high.
- `missAck` in 1: refill data valid.
- `fillRPN` in EPN_W, `fillEPN` in EPN_W, `fillDSize` in SIZE_W, `fillAttr` in ATTR_W: refill payload, sampled only when `missAck` is high.

## Operation
- EA = A + B, modulo 2^EPN_W; carry-out is discarded.
- Entry i matches when `valid[i]` is set and, for every page bit j, either EA[j] == EPN_i[j] or bit j is masked. Bits [0:EPN_W-15] are never masked. A set mask bit means the page is larger and that bit pair is ignored.
- Multiple matches: the lowest index wins.
- RA[j] = RPN_w[j] | (EA[j] & mask_w(j)), where w is the winning entry.
- `msrDR`=0 and a lookup is accepted: `Hit`=1, `RA`=EA, `attr_out`=0, no miss is raised.
- FSM states: IDLE, REQ, FILL.
  - IDLE: an accepted lookup with no match sets `Miss`=1 next cycle, latches `missEPN`=EA, and moves to REQ.
  - REQ: `missReq`=1 until `missAck`. On `missAck`, the payload is registered and the FSM moves to FILL.
  - FILL: writes the victim entry, sets its valid bit, then returns to IDLE.
- `lookupVal` is ignored while `busy`=1; `Hit` and `Miss` stay 0. The pipeline retries the lookup.
- Victim selection: the lowest-index invalid entry; if all entries are valid, the round-robin pointer `rrPtr`. `rrPtr` increments (mod ENTRIES) only when it supplied the victim.
- `invalidate`: all valid bits clear next cycle.
  - In REQ or FILL it aborts the refill: FSM goes to IDLE and `missReq` drops next cycle.
  - A `missAck` in the same cycle as `invalidate` is discarded.
  - A lookup in the same cycle as `invalidate` is ignored.

## Timing
- Lookup latency is 1: request at cycle T gives `Hit`/`Miss`/`RA`/`attr_out` at T+1. Each is a single-cycle pulse per accepted lookup.
- Miss at T+1: `missReq` is high from T+1. Ack at cycle K, FILL at K+1, `busy` low at K+2. A retried lookup at K+2 hits at K+3.
- The refilled entry is visible to lookups issued on or after the cycle following FILL.
- Reset values: `Hit`=0, `Miss`=0, `RA`=0, `attr_out`=0, `busy`=0, `missReq`=0, `missEPN`=0, all valid bits 0, `rrPtr`=0, FSM IDLE. Reset during REQ drops `missReq` the next cycle.
- Only valid bits, `rrPtr`, FSM and output registers are reset; entry payload storage is not.

## Structure
- Package `p405s_dtlb_pkg`:
  - FSM state enum.
  - Attribute bit indices (I..zonePR).
  - Mask-to-bit mapping function.
  - Default parameter constants.
- Sub-module `p405s_dtlb_dsEntry`, instantiated ENTRIES times. It holds one entry's storage and valid bit, and provides the masked compare and RA munge.
- The top level owns the adder, priority select, victim select, FSM and output registers.

## Test plan
- Reset, then lookup with msrDR=1, A=0x000100, B=0x000023 → T+1 `Miss`=1, `missEPN`=0x000123. `missReq` held through 3 idle cycles. Ack with RPN=0x2ABC00, DSize=0, attr=0x81 → retried lookup gives `Hit`=1, RA=0x2ABC00, attr=0x81.
- Entry with EPN=0x001000, DSize=7'b0000011, RPN=0x300000; lookup EA=0x001005 → `Hit`, RA=0x300005. EA=0x001015 → `Miss` (bit 17 unmasked).
- Adder wrap: A=0x3FFFFF, B=0x000002 → EA=0x000001; matches an entry with EPN=0x000001.
- Fill ENTRIES+2 distinct pages → the first ENTRIES fills use entries 0..ENTRIES-1. The next two overwrite entries 0 and 1; the original pages 0 and 1 now miss.
- `invalidate` asserted in REQ together with `missAck` → next cycle `missReq`=0, `busy`=0, no entry written, all prior hits now miss.
- msrDR=0, EA=0x155555 → `Hit`=1, RA=0x155555, attr=0, `missReq` never rises. Lookups while `busy`=1 → `Hit`=`Miss`=0.
